// File: rtl/osc_reset_ctrl.sv
// Purpose: divided oscillator with standby, plus power-up and global-reset sequencing.
// Latency: every output is registered, so each reacts one clk cycle after its inputs.
// Backpressure: none; this block free-runs and has no handshake with downstream logic.
module osc_reset_ctrl #(
  parameter int DIV            = 4,
  parameter int PUR_CYCLES     = 16,
  parameter int GSR_MIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic stdby,
  input  logic pur_n,
  input  logic gsr_n,
  output logic osc_out,
  output logic osc_en,
  output logic sedstdby,
  output logic por_done,
  output logic global_rst_n
);

  // Parameter-derived constants, sized to the 8-bit counters.
  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
  localparam logic [7:0] CNT_HALF = 8'(DIV / 2);
  localparam logic [7:0] PUR_LAST = 8'(PUR_CYCLES);
  localparam logic [7:0] GSR_LOAD = 8'(GSR_MIN_CYCLES);

  logic [7:0] cnt;
  logic [7:0] pur_cnt;
  logic [7:0] stretch_cnt;
  logic       gsr_meta;
  logic       gsr_sync;

  // Phase counter and oscillator outputs. Standby parks the counter at 0, so the
  // first cycle after release always starts with the high phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      osc_out <= 1'b0;
      osc_en  <= 1'b0;
    end else if (stdby) begin
      cnt     <= '0;
      osc_out <= 1'b0;
      osc_en  <= 1'b0;
    end else begin
      cnt     <= (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
      // For odd DIV the floor makes the high phase the shorter one.
      osc_out <= (cnt < CNT_HALF);
      osc_en  <= (cnt == CNT_LAST);
    end
  end

  // Standby status echo.
  always_ff @(posedge clk) begin
    if (rst) begin
      sedstdby <= 1'b0;
    end else begin
      sedstdby <= stdby;
    end
  end

  // Power-up counter: held at 0 while pur_n is low, saturates at PUR_CYCLES.
  always_ff @(posedge clk) begin
    if (rst || !pur_n) begin
      pur_cnt <= '0;
    end else if (pur_cnt != PUR_LAST) begin
      pur_cnt <= pur_cnt + 8'd1;
    end
  end

  // PUR_CYCLES is at least 1, so a cleared counter always reads as not done.
  assign por_done = (pur_cnt == PUR_LAST);

  // Two-flop synchronizer for the asynchronous gsr_n; reset leaves the request active.
  always_ff @(posedge clk) begin
    if (rst) begin
      gsr_meta <= 1'b0;
      gsr_sync <= 1'b0;
    end else begin
      gsr_meta <= gsr_n;
      gsr_sync <= gsr_meta;
    end
  end

  // Stretch counter: reloaded while the request is seen, then drains to 0. This
  // keeps even a single-cycle captured request visible for GSR_MIN_CYCLES more cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stretch_cnt <= '0;
    end else if (!gsr_sync) begin
      stretch_cnt <= GSR_LOAD;
    end else if (stretch_cnt != 8'd0) begin
      stretch_cnt <= stretch_cnt - 8'd1;
    end
  end

  // Global reset release needs power-up done, no live request and a drained stretch.
  // Standby has no influence here.
  always_ff @(posedge clk) begin
    if (rst) begin
      global_rst_n <= 1'b0;
    end else begin
      global_rst_n <= por_done && gsr_sync && (stretch_cnt == 8'd0);
    end
  end

endmodule

// File: tb/tb_osc_reset_ctrl.sv
// Purpose: randomized and directed stimulus for osc_reset_ctrl against a cycle-level reference.
// Latency: reference predicts each output one clk cycle after the inputs it depends on.
// Backpressure: not applicable; the bench drives one input vector per clk cycle.
module tb_osc_reset_ctrl;

  localparam int DIV  = 4;
  localparam int PUR  = 16;
  localparam int GMIN = 4;

  logic clk = 1'b0;
  logic rst, stdby, pur_n, gsr_n;
  logic osc_out, osc_en, sedstdby, por_done, global_rst_n;

  osc_reset_ctrl #(.DIV(DIV), .PUR_CYCLES(PUR), .GSR_MIN_CYCLES(GMIN)) dut (
    .clk(clk), .rst(rst), .stdby(stdby), .pur_n(pur_n), .gsr_n(gsr_n),
    .osc_out(osc_out), .osc_en(osc_en), .sedstdby(sedstdby),
    .por_done(por_done), .global_rst_n(global_rst_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference state, described in terms of elapsed cycles rather than the counters.
  int run_len   = 0;   // cycles counted since the last reset or standby cycle
  int pur_hi    = 0;   // consecutive cycles with pur_n high since reset
  bit gsr_prev  = 0;   // gsr_n captured one edge ago (0 right after reset)
  int since_low = 0;   // cycles since the synchronized request was last seen low
  bit m_valid   = 0;
  bit e_osc, e_en, e_sed, e_por, e_grn;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one input vector for one cycle, advance the reference, check all outputs.
  task automatic step(input bit r, input bit s, input bit p, input bit g);
    bit por_before, quiet_before, new_sync;
    int ph;
    rst = r; stdby = s; pur_n = p; gsr_n = g;
    @(posedge clk);
    por_before   = (pur_hi >= PUR);
    quiet_before = (since_low > GMIN);
    if (r) begin
      e_osc = 0; e_en = 0; e_sed = 0; e_grn = 0;
      run_len = 0; pur_hi = 0; gsr_prev = 0; since_low = 0;
      m_valid = 1;
    end else begin
      if (s) begin
        e_osc = 0; e_en = 0; run_len = 0;
      end else begin
        ph = run_len % DIV;
        e_osc = (ph < DIV / 2);
        e_en  = (ph == DIV - 1);
        run_len++;
      end
      e_sed  = s;
      pur_hi = p ? pur_hi + 1 : 0;
      e_grn  = por_before && quiet_before;
      new_sync  = gsr_prev;
      gsr_prev  = g;
      since_low = new_sync ? since_low + 1 : 0;
    end
    e_por = (pur_hi >= PUR);
    @(negedge clk);
    if (m_valid) begin
      check_eq("osc_out", int'(osc_out), int'(e_osc));
      check_eq("osc_en", int'(osc_en), int'(e_en));
      check_eq("sedstdby", int'(sedstdby), int'(e_sed));
      check_eq("por_done", int'(por_done), int'(e_por));
      check_eq("global_rst_n", int'(global_rst_n), int'(e_grn));
    end
  endtask

  initial begin
    logic [7:0] osc_pat, en_pat;
    int n, w;
    bit s_r, p_r;

    // Reset state.
    rst = 1; stdby = 0; pur_n = 0; gsr_n = 1;
    repeat (3) step(1, 0, 0, 1);
    check_eq("rst_outputs", int'({osc_out, osc_en, sedstdby, por_done, global_rst_n}), 0);

    // Oscillator pattern after reset, and power-up timing with pur_n raised one cycle late.
    step(0, 0, 0, 1);
    osc_pat = '0; en_pat = '0;
    // The first oscillator cycle was the step above; collect seven more plus that one.
    osc_pat[7] = osc_out; en_pat[7] = osc_en;
    n = 0;
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1, 1);
      n++;
      osc_pat[i] = osc_out; en_pat[i] = osc_en;
    end
    check_eq("osc_pattern", int'(osc_pat), int'(8'b1100_1100));
    check_eq("osc_en_pattern", int'(en_pat), int'(8'b0001_0001));
    while (!por_done && n < 40) begin
      step(0, 0, 1, 1);
      n++;
    end
    check_eq("por_latency", n, PUR);
    step(0, 0, 1, 1);
    check_eq("grst_release", int'(global_rst_n), 1);

    // Single-cycle gsr_n pulse after power-up must stretch the global reset.
    step(0, 0, 1, 0);
    w = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 1);
      if (!global_rst_n) w++;
    end
    check_eq("gsr_min_width", int'(w >= GMIN), 1);
    check_eq("gsr_pulse_end", int'(global_rst_n), 1);

    // Standby for ten cycles mid-period, then restart in the high phase.
    step(0, 0, 1, 1);
    repeat (10) begin
      step(0, 1, 1, 1);
      check_eq("stdby_osc", int'({osc_out, osc_en}), 0);
    end
    step(0, 0, 1, 1);
    check_eq("stdby_restart", int'(osc_out), 1);
    check_eq("stdby_grst", int'(global_rst_n), 1);

    // pur_n dropped at count 8 restarts the whole power-up count.
    step(1, 0, 0, 1);
    repeat (8) step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check_eq("pur_drop_por", int'(por_done), 0);
    n = 0;
    while (!por_done && n < 40) begin
      step(0, 0, 1, 1);
      n++;
    end
    check_eq("pur_restart_latency", n, PUR);

    // Reset mid-stretch while osc_out is high clears every output.
    repeat (4) step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    n = 0;
    while (!osc_out && n < 8) begin
      step(0, 0, 1, 1);
      n++;
    end
    check_eq("pre_rst_osc_high", int'(osc_out), 1);
    step(1, 0, 1, 1);
    check_eq("rst_override", int'({osc_out, osc_en, sedstdby, por_done, global_rst_n}), 0);

    // Randomized traffic: runs of standby, occasional pur_n drops, gsr pulses, rare resets.
    s_r = 0; p_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) s_r = ~s_r;
      p_r = ($urandom_range(0, 99) >= 2);
      step(($urandom_range(0, 149) == 0), s_r, p_r, ($urandom_range(0, 24) != 0));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
